// File: rtl/hit_pkg.sv
// Shared constants and types for the HIT configuration path: frame geometry,
// decoder addresses and the serial receiver state encoding.
package hit_pkg;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FRAME_W = ADDR_W + DATA_W + 1;

  // Decoder targets; address 0 is delivered but ignored downstream
  localparam logic [ADDR_W-1:0] PLL   = 2'd1;
  localparam logic [ADDR_W-1:0] TRNG  = 2'd2;
  localparam logic [ADDR_W-1:0] NOISE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DRAIN
  } rx_state_t;

endpackage

// File: rtl/hit_serial_rx.sv
// Strobed serial frame receiver: shifts in address/data/parity MSB first,
// checks length, even parity and inter-strobe timeout, and registers results.
module hit_serial_rx #(
  parameter int unsigned ADDR_W  = hit_pkg::ADDR_W,
  parameter int unsigned DATA_W  = hit_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sstb,
  input  logic              sdi,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              err_parity,
  output logic              err_length,
  output logic              err_timeout,
  output logic              busy
);
  import hit_pkg::*;

  localparam int unsigned FrameW = ADDR_W + DATA_W + 1;
  localparam int unsigned CntW   = $clog2(FrameW + 1);
  localparam int unsigned TmrW   = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(FrameW);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  rx_state_t         state_q;
  logic              sen_q;
  logic [FrameW-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;
  logic [TmrW-1:0]   tmr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      // Reset high so a frame already in flight is not mistaken for a new one
      sen_q       <= 1'b1;
      shreg_q     <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      valid       <= 1'b0;
      err_parity  <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
      address     <= '0;
      data        <= '0;
    end else begin
      sen_q       <= sen;
      valid       <= 1'b0;
      err_parity  <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sen && !sen_q) begin
            state_q <= S_SHIFT;
            busy    <= 1'b1;
            tmr_q   <= '0;
            if (sstb) begin
              shreg_q <= FrameW'(sdi);
              cnt_q   <= CntW'(1);
            end else begin
              shreg_q <= '0;
              cnt_q   <= '0;
            end
          end
        end
        S_SHIFT: begin
          if (sstb && sen) begin
            if (cnt_q == CntFull) begin
              err_length <= 1'b1;
              state_q    <= S_DRAIN;
            end else begin
              shreg_q <= {shreg_q[FrameW-2:0], sdi};
              cnt_q   <= cnt_q + 1'b1;
              tmr_q   <= '0;
            end
          end else if (tmr_q == TmrLast) begin
            // Checked before sen so a coincident timeout takes priority
            err_timeout <= 1'b1;
            state_q     <= S_DRAIN;
          end else if (!sen) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            if (cnt_q != CntFull) begin
              err_length <= 1'b1;
            end else if (^shreg_q) begin
              err_parity <= 1'b1;
            end else begin
              valid   <= 1'b1;
              address <= shreg_q[FrameW-1 -: ADDR_W];
              data    <= shreg_q[DATA_W:1];
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (!sen) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hit_serial_rx.sv
// Self-checking bench for hit_serial_rx: directed frames with a queue of
// expected address/data words popped whenever valid is observed.
module tb_hit_serial_rx;

  logic        clk;
  logic        rst;
  logic        sen;
  logic        sstb;
  logic        sdi;
  logic        valid;
  logic [1:0]  address;
  logic [15:0] data;
  logic        err_parity;
  logic        err_length;
  logic        err_timeout;
  logic        busy;

  int checks;
  int errors;

  // Pulse counters, written only by the watcher below
  int n_valid;
  int n_perr;
  int n_lerr;
  int n_terr;
  int n_multi;

  logic [17:0] exp_q[$];

  hit_serial_rx #(
    .ADDR_W (2),
    .DATA_W (16),
    .TIMEOUT(255)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sen        (sen),
    .sstb       (sstb),
    .sdi        (sdi),
    .valid      (valid),
    .address    (address),
    .data       (data),
    .err_parity (err_parity),
    .err_length (err_length),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_valid = 0;
    n_perr  = 0;
    n_lerr  = 0;
    n_terr  = 0;
    n_multi = 0;
  end

  always @(negedge clk) begin
    if (valid === 1'b1) n_valid++;
    if (err_parity === 1'b1) n_perr++;
    if (err_length === 1'b1) n_lerr++;
    if (err_timeout === 1'b1) n_terr++;
    if ((32'(valid) + 32'(err_parity) + 32'(err_length) + 32'(err_timeout)) > 1) n_multi++;
  end

  function automatic logic [18:0] mk_frame(input logic [1:0] a, input logic [15:0] d,
                                           input logic flip);
    return {a, d, (^{a, d}) ^ flip};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    sen  = 1'b1;
    sstb = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic b);
    sstb = 1'b1;
    sdi  = b;
    tick();
    sstb = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) strobe(bits[n-1-i]);
  endtask

  task automatic end_frame();
    sen = 1'b0;
    tick();
  endtask

  // Called right after end_frame: expects a valid pulse and pops the scoreboard
  task automatic take_valid(input string name);
    logic [17:0] exp;
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: valid got %b want 1", name, valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: valid got 1 with empty scoreboard want 0", name);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if ({address, data} !== exp) begin
        errors++;
        $display("FAIL %s: addr/data got %h/%h want %h/%h", name, address, data,
                 exp[17:16], exp[15:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    sen  = 1'b0;
    sstb = 1'b0;
    sdi  = 1'b0;
    tick();
    tick();
    checks++;
    if ({valid, err_parity, err_length, err_timeout, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {valid, err_parity, err_length, err_timeout, busy});
    end
    checks++;
    if ({address, data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h want 0/0000", address, data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good();
    int v0 = n_valid;
    int e0 = n_perr + n_lerr + n_terr;
    exp_q.push_back({2'd1, 16'h1A05});
    start_frame();
    send_bits(32'(mk_frame(2'd1, 16'h1A05, 1'b0)), 19);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL good_busy: got %b want 1", busy);
    end
    end_frame();
    take_valid("good_valid");
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_after: valid/busy got %b/%b want 0/0", valid, busy);
    end
    checks++;
    if (n_valid - v0 != 1 || n_perr + n_lerr + n_terr - e0 != 0) begin
      errors++;
      $display("FAIL good_pulses: valid/err got %0d/%0d want 1/0", n_valid - v0,
               n_perr + n_lerr + n_terr - e0);
    end
  endtask

  task automatic test_parity();
    int v0 = n_valid;
    start_frame();
    send_bits(32'(mk_frame(2'd1, 16'h1A05, 1'b1)), 19);
    end_frame();
    checks++;
    if (err_parity !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_pulse: err_parity/valid got %b/%b want 1/0", err_parity, valid);
    end
    checks++;
    if (address !== 2'd1 || data !== 16'h1A05) begin
      errors++;
      $display("FAIL parity_hold: got %h/%h want 1/1a05", address, data);
    end
    tick();
    checks++;
    if (n_valid != v0) begin
      errors++;
      $display("FAIL parity_novalid: valid pulses got %0d want 0", n_valid - v0);
    end
  endtask

  task automatic test_length();
    int l0 = n_lerr;
    start_frame();
    send_bits(32'h0001_5555, 18);
    end_frame();
    checks++;
    if (err_length !== 1'b1) begin
      errors++;
      $display("FAIL length_short: err_length got %b want 1", err_length);
    end
    tick();
    start_frame();
    send_bits(32'(mk_frame(2'd2, 16'h1234, 1'b0)), 19);
    sstb = 1'b1;
    sdi  = 1'b1;
    tick();
    sstb = 1'b0;
    checks++;
    if (err_length !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL length_long_at20: err_length/busy got %b/%b want 1/1", err_length, busy);
    end
    tick();
    strobe(1'b0);
    checks++;
    if (busy !== 1'b1 || err_length !== 1'b0) begin
      errors++;
      $display("FAIL length_long_drain: busy/err_length got %b/%b want 1/0", busy, err_length);
    end
    end_frame();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL length_long_exit: busy/valid got %b/%b want 0/0", busy, valid);
    end
    tick();
    checks++;
    if (n_lerr - l0 != 2) begin
      errors++;
      $display("FAIL length_count: err_length pulses got %0d want 2", n_lerr - l0);
    end
  endtask

  task automatic test_timeout();
    int t0 = n_terr;
    int o0 = n_valid + n_perr + n_lerr;
    start_frame();
    send_bits(32'h0000_02AA, 10);
    // Now one edge past the 10th strobe; pulse due after the 255th edge
    repeat (253) tick();
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: err_timeout got %b want 0", err_timeout);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: err_timeout got %b want 1", err_timeout);
    end
    send_bits(32'h0000_0005, 3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_drain: busy got %b want 1", busy);
    end
    end_frame();
    tick();
    checks++;
    if (busy !== 1'b0 || n_terr - t0 != 1 || n_valid + n_perr + n_lerr != o0) begin
      errors++;
      $display("FAIL timeout_exit: busy %b timeouts %0d others %0d want 0/1/0", busy,
               n_terr - t0, n_valid + n_perr + n_lerr - o0);
    end
  endtask

  task automatic test_reset_midframe();
    int p0 = n_valid + n_perr + n_lerr + n_terr;
    start_frame();
    send_bits(32'h0000_00A5, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_busy: got %b want 0", busy);
    end
    send_bits(32'h0000_07FF, 11);
    end_frame();
    tick();
    checks++;
    if (n_valid + n_perr + n_lerr + n_terr != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: pulses got %0d busy %b want 0/0",
               n_valid + n_perr + n_lerr + n_terr - p0, busy);
    end
    exp_q.push_back({2'd3, 16'hFFFF});
    start_frame();
    send_bits(32'(mk_frame(2'd3, 16'hFFFF, 1'b0)), 19);
    end_frame();
    take_valid("midrst_next_valid");
    tick();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({2'd2, 16'h0042});
    exp_q.push_back({2'd1, 16'h8001});
    start_frame();
    send_bits(32'(mk_frame(2'd2, 16'h0042, 1'b0)), 19);
    end_frame();
    take_valid("b2b_first");
    start_frame();
    send_bits(32'(mk_frame(2'd1, 16'h8001, 1'b0)), 19);
    end_frame();
    take_valid("b2b_second");
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: pending got %0d want 0", exp_q.size());
    end
    checks++;
    if (n_multi != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: overlapping cycles got %0d want 0", n_multi);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_good();
    test_parity();
    test_length();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
